sar_search_ctrl: RTL and testbench

Binary-search (successive-approximation) initiator that drives the operand side of an external magnitude comparator. It finds an unknown target held on the comparator's other input.
- Each probe cycle presents a guess on `guess`.
- The comparator compares `guess` (its a input) against the target (its b input) and returns eq/lt/gt.
- The controller narrows its search bounds using those flags.
- When the search ends, it reports the found value, the number of probes taken and a status.

---
 rtl/sar_search_ctrl_pkg.sv | 25 ++
 rtl/sar_search_ctrl_if.sv | 31 +++
 rtl/sar_search_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sar_search_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sar_search_ctrl_pkg.sv
// Shared types and sizing helpers for the successive-approximation search controller.
// Imported by the controller and its interface.
package sar_search_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DONE
    } state_t;

    // Decoded comparator verdict for the current probe.
    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_LT,
        CMP_GT,
        CMP_BAD
    } cmp_t;

    function automatic int steps_w(input int max_probes);
        return $clog2(max_probes + 1);
    endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Bundle between the search controller (master) and the comparator/host side (slave).
// Widths follow the controller parameters; steps is sized to count up to MAX_PROBES.
interface sar_search_ctrl_if #(
    parameter int WIDTH      = sar_search_pkg::DEF_WIDTH,
    parameter int MAX_PROBES = WIDTH + 1
);
    localparam int SW = sar_search_pkg::steps_w(MAX_PROBES);

    logic             start;
    logic [WIDTH-1:0] guess;
    logic             ceq;
    logic             clt;
    logic             cgt;
    logic             busy;
    logic             done;
    logic             found;
    logic [WIDTH-1:0] result;
    logic [SW-1:0]    steps;
    logic             err;

    modport master (
        input  start, ceq, clt, cgt,
        output guess, busy, done, found, result, steps, err
    );

    modport slave (
        output start, ceq, clt, cgt,
        input  guess, busy, done, found, result, steps, err
    );

endinterface

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator driving comparator operand a; narrows [lo,hi] from eq/lt/gt flags.
// Latency: first guess 1 cycle after start, done pulse n+1 cycles after start for n probes.
// Backpressure: none; start is only sampled in IDLE. SAR_ERRCHK_EN enables one-hot flag checking.
module sar_search_ctrl
    import sar_search_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MAX_PROBES = WIDTH + 1
) (
    input  logic               clk,
    input  logic               rst,
    sar_search_ctrl_if.master  bus
);

    localparam int SW = steps_w(MAX_PROBES);

    localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] GUESS_INIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] VAL_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] VAL_MIN    = '0;
    localparam logic [SW-1:0]    STEPS_MAX  = SW'(MAX_PROBES);

    state_t           state_q;
    logic [WIDTH-1:0] guess_q;
    logic [WIDTH:0]   lo_q;
    logic [WIDTH:0]   hi_q;
    logic             busy_q;
    logic             done_q;
    logic             found_q;
    logic [WIDTH-1:0] result_q;
    logic [SW-1:0]    steps_q;
    logic             err_q;

    cmp_t             cmp;
    logic [WIDTH:0]   guess_w;
    logic [WIDTH:0]   lo_nxt;
    logic [WIDTH:0]   hi_nxt;
    logic [WIDTH:0]   mid_sum;
    logic [WIDTH-1:0] mid_nxt;
    logic [SW-1:0]    steps_nxt;
    logic             fin;
    logic             hit;
    logic             bad;

    // Flag decode; all-low is read as "guess too high" so the search keeps descending.
    always_comb begin
        cmp = CMP_GT;
`ifdef SAR_ERRCHK_EN
        if (!$onehot({bus.ceq, bus.clt, bus.cgt})) begin
            cmp = CMP_BAD;
        end else if (bus.ceq) begin
            cmp = CMP_EQ;
        end else if (bus.clt) begin
            cmp = CMP_LT;
        end
`else
        if (bus.ceq) begin
            cmp = CMP_EQ;
        end else if (bus.clt) begin
            cmp = CMP_LT;
        end else if (bus.cgt) begin
            cmp = CMP_GT;
        end
`endif
    end

    // Next bounds and termination for the probe currently on the bus.
    always_comb begin
        guess_w   = {1'b0, guess_q};
        lo_nxt    = lo_q;
        hi_nxt    = hi_q;
        fin       = 1'b0;
        hit       = 1'b0;
        bad       = 1'b0;
        steps_nxt = steps_q + 1'b1;

        case (cmp)
            CMP_EQ: begin
                hit = 1'b1;
                fin = 1'b1;
            end
            CMP_LT: begin
                lo_nxt = guess_w + 1'b1;
                if (guess_q == VAL_MAX) fin = 1'b1;
            end
            CMP_GT: begin
                hi_nxt = guess_w - 1'b1;
                if (guess_q == VAL_MIN) fin = 1'b1;
            end
            default: begin
                bad = 1'b1;
                fin = 1'b1;
            end
        endcase

        if (lo_nxt > hi_nxt)         fin = 1'b1;
        if (steps_nxt == STEPS_MAX)  fin = 1'b1;

        // Midpoint in WIDTH+1 bits; dropping bit 0 is the >>1.
        mid_sum = lo_nxt + hi_nxt;
        mid_nxt = mid_sum[WIDTH:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            lo_q     <= '0;
            hi_q     <= HI_INIT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            result_q <= '0;
            steps_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        lo_q    <= '0;
                        hi_q    <= HI_INIT;
                        steps_q <= '0;
                        found_q <= 1'b0;
                        err_q   <= 1'b0;
                        guess_q <= GUESS_INIT;
                        busy_q  <= 1'b1;
                        state_q <= PROBE;
                    end
                end
                PROBE: begin
                    steps_q <= steps_nxt;
                    lo_q    <= lo_nxt;
                    hi_q    <= hi_nxt;
                    if (fin) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        found_q <= hit;
                        err_q   <= bad;
                        if (hit) result_q <= guess_q;
                        state_q <= DONE;
                    end else begin
                        guess_q <= mid_nxt;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.result = result_q;
    assign bus.steps  = steps_q;
`ifdef SAR_ERRCHK_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: golden comparator responder plus a queue-based search model.
// Covers directed targets, all-low flags, random targets, reset abort and held start.
module tb_sar_search_ctrl;

    localparam int WIDTH = 4;
    localparam int MAXP  = WIDTH + 1;
`ifdef SAR_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] target;
    logic             zero_flags;

    int total;
    int bad;

    sar_search_ctrl_if #(.WIDTH(WIDTH), .MAX_PROBES(MAXP)) bus ();

    sar_search_ctrl #(.WIDTH(WIDTH), .MAX_PROBES(MAXP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Golden magnitude comparator: a = guess, b = target.
    assign bus.ceq = zero_flags ? 1'b0 : (bus.guess == target);
    assign bus.clt = zero_flags ? 1'b0 : (bus.guess <  target);
    assign bus.cgt = zero_flags ? 1'b0 : (bus.guess >  target);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Plain binary search over integers; zero mode means every flag is low.
    task automatic model(input int t, input bit zero, output int gs[$],
                         output int n, output bit mfound, output bit merr);
        int lo, hi, g;
        lo = 0; hi = (1 << WIDTH) - 1; n = 0; mfound = 0; merr = 0;
        gs = {};
        while (1) begin
            g = (lo + hi) / 2;
            gs.push_back(g);
            n++;
            if (zero && ERRCHK) begin merr = 1; break; end
            if (!zero && g == t) begin mfound = 1; break; end
            if (!zero && g < t) lo = g + 1;
            else                hi = g - 1;
            if (lo > hi || n == MAXP) break;
        end
    endtask

    task automatic run_search(input int t, input bit zero, input bit poke);
        int exp_g[$];
        int obs_g[$];
        int n, cyc;
        bit mf, me;
        model(t, zero, exp_g, n, mf, me);
        target     = WIDTH'(t);
        zero_flags = zero;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        obs_g = {};
        while (!bus.done && cyc < 40) begin
            if (bus.busy) obs_g.push_back(int'(bus.guess));
            if (poke && cyc == 2) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        chk($sformatf("done_seen_t%0d", t), bus.done, 1);
        chk($sformatf("latency_t%0d", t), cyc, n + 1);
        chk($sformatf("nprobes_t%0d", t), obs_g.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++)
            chk($sformatf("guess%0d_t%0d", i, t), obs_g[i], exp_g[i]);
        chk($sformatf("found_t%0d", t), bus.found, mf);
        if (mf) chk($sformatf("result_t%0d", t), bus.result, t);
        chk($sformatf("steps_t%0d", t), bus.steps, n);
        chk($sformatf("err_t%0d", t), bus.err, me);
        chk($sformatf("busy_in_done_t%0d", t), bus.busy, 0);
        @(negedge clk);
        chk($sformatf("done_pulse_t%0d", t), bus.done, 0);
        @(negedge clk);
        chk($sformatf("idle_after_t%0d", t), bus.busy, 0);
        chk($sformatf("hold_found_t%0d", t), bus.found, mf);
    endtask

    initial begin
        int cyc;
        bit saw_done;
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        target = '0;
        zero_flags = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_guess",  bus.guess,  0);
        chk("rst_busy",   bus.busy,   0);
        chk("rst_done",   bus.done,   0);
        chk("rst_found",  bus.found,  0);
        chk("rst_result", bus.result, 0);
        chk("rst_steps",  bus.steps,  0);
        chk("rst_err",    bus.err,    0);
        rst = 1'b0;
        @(negedge clk);

        run_search(9,  1'b0, 1'b0);
        run_search(15, 1'b0, 1'b0);
        run_search(0,  1'b0, 1'b0);
        run_search(5,  1'b1, 1'b0);
        run_search(6,  1'b0, 1'b1);

        for (int k = 0; k < 20; k++)
            run_search(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0, ($urandom_range(0, 1) == 1));

        // Reset while a search is in flight.
        target = 4'd12;
        zero_flags = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_guess",  bus.guess,  0);
        chk("abort_busy",   bus.busy,   0);
        chk("abort_done",   bus.done,   0);
        chk("abort_found",  bus.found,  0);
        chk("abort_result", bus.result, 0);
        chk("abort_steps",  bus.steps,  0);
        chk("abort_err",    bus.err,    0);
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("abort_quiet", saw_done, 0);

        // Start held high: next search begins on the IDLE cycle after DONE.
        target = 4'd3;
        bus.start = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_done_seen", bus.done, 1);
        @(negedge clk);
        chk("held_idle_gap", bus.busy, 0);
        @(negedge clk);
        chk("held_restart", bus.busy, 1);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_second_found", bus.found, 1);
        chk("held_second_result", bus.result, 3);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
